// File: rtl/vx_mem_line_splitter.sv
// vx_mem_line_splitter
// Turns one line-wide VX memory request into a sequence of 32-bit word
// requests for the downstream bridge. Writes become one word write per
// enabled word; reads fetch every word in order and are gathered back into a
// single line response carrying the original tag. One line is in flight at a
// time, and every output comes straight from a flop.

module vx_mem_line_splitter #(
    parameter int LINE_WIDTH_BIT     = 128,
    parameter int TAG_WIDTH_BIT      = 1,
    parameter int WORD_TAG_WIDTH_BIT = ($clog2(LINE_WIDTH_BIT / 32) > 1) ?
                                       $clog2(LINE_WIDTH_BIT / 32) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    // line side (from the L2 memory port)
    input  logic                          in_req_valid,
    input  logic                          in_req_rw,
    input  logic [LINE_WIDTH_BIT/8-1:0]   in_req_byteen,
    input  logic [31:0]                   in_req_addr,
    input  logic [LINE_WIDTH_BIT-1:0]     in_req_data,
    input  logic [TAG_WIDTH_BIT-1:0]      in_req_tag,
    output logic                          in_req_ready,
    output logic                          in_rsp_valid,
    output logic [LINE_WIDTH_BIT-1:0]     in_rsp_data,
    output logic [TAG_WIDTH_BIT-1:0]      in_rsp_tag,
    input  logic                          in_rsp_ready,

    // word side (to the 32-bit bridge)
    output logic                          out_req_valid,
    output logic                          out_req_rw,
    output logic [3:0]                    out_req_byteen,
    output logic [31:0]                   out_req_addr,
    output logic [31:0]                   out_req_data,
    output logic [WORD_TAG_WIDTH_BIT-1:0] out_req_tag,
    input  logic                          out_req_ready,
    input  logic                          out_rsp_valid,
    input  logic [31:0]                   out_rsp_data,
    input  logic [WORD_TAG_WIDTH_BIT-1:0] out_rsp_tag,
    output logic                          out_rsp_ready
);

    localparam int WORDS = LINE_WIDTH_BIT / 32;
    localparam int BE_W  = LINE_WIDTH_BIT / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = WORD_TAG_WIDTH_BIT;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        SEND_RSP = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      rw_q, rw_d;
    logic [BE_W-1:0]           byteen_q, byteen_d;
    logic [31:0]               addr_q, addr_d;
    logic [LINE_WIDTH_BIT-1:0] data_q, data_d;
    logic [TAG_WIDTH_BIT-1:0]  tag_q, tag_d;
    logic [LINE_WIDTH_BIT-1:0] gather_q, gather_d;

    logic                      in_req_ready_q, in_req_ready_d;
    logic                      in_rsp_valid_q, in_rsp_valid_d;
    logic                      out_req_valid_q, out_req_valid_d;
    logic [3:0]                out_req_byteen_q, out_req_byteen_d;
    logic [31:0]               out_req_addr_q, out_req_addr_d;
    logic [31:0]               out_req_data_q, out_req_data_d;
    logic [IDX_W-1:0]          out_req_tag_q, out_req_tag_d;
    logic                      out_rsp_ready_q, out_rsp_ready_d;

    logic                      first_found, next_found;
    logic [IDX_W-1:0]          first_idx, next_idx;

    // The returned word tag is informational only (placement uses idx) and
    // the line-offset address bits are forced to zero.
    logic unused_inputs;
    assign unused_inputs = ^{out_rsp_tag, in_req_addr[OFF_W-1:0]};

    // Locate the lowest enabled word of an incoming write and the next
    // enabled word above the current idx of the captured write.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int w = WORDS - 1; w >= 0; w--) begin
            if (in_req_byteen[w*4 +: 4] != 4'h0) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(w);
            end
            if (w > int'(idx_q) && byteen_q[w*4 +: 4] != 4'h0) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(w);
            end
        end
    end

    // Next-state logic: capture, word walk and read gathering.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rw_d     = rw_q;
        byteen_d = byteen_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tag_d    = tag_q;
        gather_d = gather_q;
        unique case (state_q)
            IDLE: begin
                if (in_req_valid && in_req_ready_q) begin
                    rw_d     = in_req_rw;
                    byteen_d = in_req_byteen;
                    addr_d   = {in_req_addr[31:OFF_W], {OFF_W{1'b0}}};
                    data_d   = in_req_data;
                    tag_d    = in_req_tag;
                    gather_d = '0;
                    if (!in_req_rw) begin
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else if (first_found) begin
                        idx_d   = first_idx;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (out_req_ready) begin
                    if (!rw_q) begin
                        state_d = WAIT_RSP;
                    end else if (next_found) begin
                        idx_d = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if (out_rsp_valid) begin
                    gather_d[int'(idx_q)*32 +: 32] = out_rsp_data;
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_d = SEND_RSP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            SEND_RSP: begin
                if (in_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        in_req_ready_d   = (state_d == IDLE);
        out_req_valid_d  = (state_d == ISSUE);
        out_rsp_ready_d  = (state_d == WAIT_RSP);
        in_rsp_valid_d   = (state_d == SEND_RSP);
        out_req_addr_d   = addr_d + {{(30 - IDX_W){1'b0}}, idx_d, 2'b00};
        out_req_byteen_d = byteen_d[int'(idx_d)*4 +: 4];
        out_req_data_d   = data_d[int'(idx_d)*32 +: 32];
        out_req_tag_d    = idx_d;
    end

    // State, capture, gather buffer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            rw_q             <= 1'b0;
            byteen_q         <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            tag_q            <= '0;
            // NOTE: the gather buffer is reset on purpose so that a line
            // aborted by reset can never leak old words into a later response.
            gather_q         <= '0;
            in_req_ready_q   <= 1'b0;
            in_rsp_valid_q   <= 1'b0;
            out_req_valid_q  <= 1'b0;
            out_req_byteen_q <= '0;
            out_req_addr_q   <= '0;
            out_req_data_q   <= '0;
            out_req_tag_q    <= '0;
            out_rsp_ready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q          <= state_d;
            idx_q            <= idx_d;
            rw_q             <= rw_d;
            byteen_q         <= byteen_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            tag_q            <= tag_d;
            gather_q         <= gather_d;
            in_req_ready_q   <= in_req_ready_d;
            in_rsp_valid_q   <= in_rsp_valid_d;
            out_req_valid_q  <= out_req_valid_d;
            out_req_byteen_q <= out_req_byteen_d;
            out_req_addr_q   <= out_req_addr_d;
            out_req_data_q   <= out_req_data_d;
            out_req_tag_q    <= out_req_tag_d;
            out_rsp_ready_q  <= out_rsp_ready_d;
        end
    end

    assign in_req_ready   = in_req_ready_q;
    assign in_rsp_valid   = in_rsp_valid_q;
    assign in_rsp_data    = gather_q;
    assign in_rsp_tag     = tag_q;
    assign out_req_valid  = out_req_valid_q;
    assign out_req_rw     = rw_q;
    assign out_req_byteen = out_req_byteen_q;
    assign out_req_addr   = out_req_addr_q;
    assign out_req_data   = out_req_data_q;
    assign out_req_tag    = out_req_tag_q;
    assign out_rsp_ready  = out_rsp_ready_q;

endmodule

// File: tb/tb_vx_mem_line_splitter.sv
// Bench for vx_mem_line_splitter: directed scenarios plus random lines, each
// checked against the expected word sequence and gathered line computed
// directly from the request (base address, enabled words, bridge data).

module tb_vx_mem_line_splitter;

    localparam int LW    = 128;
    localparam int WORDS = LW / 32;
    localparam int BE_W  = LW / 8;
    localparam int TW    = 1;
    localparam int WTW   = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            in_req_valid, in_req_rw, in_req_ready;
    logic [BE_W-1:0] in_req_byteen;
    logic [31:0]     in_req_addr;
    logic [LW-1:0]   in_req_data;
    logic [TW-1:0]   in_req_tag;
    logic            in_rsp_valid, in_rsp_ready;
    logic [LW-1:0]   in_rsp_data;
    logic [TW-1:0]   in_rsp_tag;
    logic            out_req_valid, out_req_rw, out_req_ready;
    logic [3:0]      out_req_byteen;
    logic [31:0]     out_req_addr, out_req_data;
    logic [WTW-1:0]  out_req_tag;
    logic            out_rsp_valid, out_rsp_ready;
    logic [31:0]     out_rsp_data;
    logic [WTW-1:0]  out_rsp_tag;

    vx_mem_line_splitter #(
        .LINE_WIDTH_BIT     (LW),
        .TAG_WIDTH_BIT      (TW),
        .WORD_TAG_WIDTH_BIT (WTW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_req_valid   (in_req_valid),
        .in_req_rw      (in_req_rw),
        .in_req_byteen  (in_req_byteen),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_tag     (in_req_tag),
        .in_req_ready   (in_req_ready),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .in_rsp_ready   (in_rsp_ready),
        .out_req_valid  (out_req_valid),
        .out_req_rw     (out_req_rw),
        .out_req_byteen (out_req_byteen),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_tag    (out_req_tag),
        .out_req_ready  (out_req_ready),
        .out_rsp_valid  (out_rsp_valid),
        .out_rsp_data   (out_rsp_data),
        .out_rsp_tag    (out_rsp_tag),
        .out_rsp_ready  (out_rsp_ready)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int mon_busy = 0;
    int mon_spur = 0;
    bit mon_probe = 1'b0;
    bit mon_write = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return {52'b0, in_req_ready, in_rsp_valid, in_rsp_data, in_rsp_tag, out_req_valid,
                out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag, out_rsp_ready};
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] l;
        for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic idle_inputs();
        in_req_valid  = 1'b0;
        in_req_rw     = 1'b0;
        in_req_byteen = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_tag    = '0;
        in_rsp_ready  = 1'b0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        out_rsp_tag   = '0;
    endtask

    // Advance to the next falling edge and update the protocol monitors.
    task automatic tick();
        @(negedge clk_i);
        if (mon_probe && in_req_ready) mon_busy++;
        if (mon_write && in_rsp_valid) mon_spur++;
    endtask

    // One complete line transaction. Called and returns just after a falling
    // edge. req_stall < 0 selects random out_req_ready / bridge delays.
    // abort_word >= 0 pulses reset after that word's request is accepted.
    task automatic run_line(input logic rw, input logic [BE_W-1:0] be, input logic [31:0] addr,
                            input logic [LW-1:0] wdata, input logic [TW-1:0] tag,
                            input logic [LW-1:0] rd_line, input int req_stall,
                            input int rsp_stall, input bit probe_busy, input int abort_word);
        int          exp_idx[$];
        logic [31:0] base;
        int          t, stall, dly;
        int unsigned c0;
        base = addr & ~32'(BE_W - 1);
        for (int w = 0; w < WORDS; w++)
            if (!rw || be[w*4 +: 4] != 4'h0) exp_idx.push_back(w);

        in_req_valid  = 1'b1;
        in_req_rw     = rw;
        in_req_byteen = be;
        in_req_addr   = addr;
        in_req_data   = wdata;
        in_req_tag    = tag;
        t = 0;
        while (!in_req_ready && t < 100) begin tick(); t++; end
        check("req_accept", in_req_ready, 1);
        if (!in_req_ready) begin idle_inputs(); return; end
        mon_write = rw;
        mon_spur  = 0;
        tick();
        c0 = cyc;
        if (probe_busy) begin
            mon_probe = 1'b1;
            mon_busy  = 0;
        end else begin
            in_req_valid = 1'b0;
        end

        foreach (exp_idx[k]) begin
            int w;
            w     = exp_idx[k];
            stall = (req_stall < 0) ? int'($urandom_range(0, 2)) : req_stall;
            t = 0;
            while (!out_req_valid && t < 50) begin tick(); t++; end
            check("out_req_valid", out_req_valid, 1);
            if (!out_req_valid) begin idle_inputs(); return; end
            for (int s = 0; s <= stall; s++) begin
                check("req_valid_hold", out_req_valid, 1);
                check("req_addr", out_req_addr, base + 32'(4 * w));
                check("req_be", out_req_byteen, be[w*4 +: 4]);
                check("req_data", out_req_data, wdata[w*32 +: 32]);
                check("req_tag", out_req_tag, w);
                check("req_rw", out_req_rw, rw);
                out_req_ready = (s == stall);
                tick();
            end
            out_req_ready = 1'b0;
            if (!rw) begin
                if (abort_word == w) begin
                    #2 rst_ni = 1'b0;
                    #1 check("abort_outputs_zero", all_outputs(), '0);
                    @(negedge clk_i);
                    check("abort_held_zero", all_outputs(), '0);
                    rst_ni = 1'b1;
                    idle_inputs();
                    mon_probe = 1'b0;
                    return;
                end
                dly = (req_stall < 0) ? int'($urandom_range(0, 2)) : 0;
                for (int d = 0; d < dly; d++) tick();
                out_rsp_valid = 1'b1;
                out_rsp_data  = rd_line[w*32 +: 32];
                out_rsp_tag   = WTW'(w);
                check("rsp_ready", out_rsp_ready, 1);
                tick();
                out_rsp_valid = 1'b0;
            end
        end

        if (rw) begin
            // Back in IDLE right after the last word (or the accept, if none).
            check("wr_idle_ready", in_req_ready, 1);
            check("wr_no_req", out_req_valid, 0);
            if (exp_idx.size() == 0) begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check("wr_zero_no_req", out_req_valid, 0);
                end
            end
            check("wr_no_rsp", mon_spur, 0);
        end else begin
            t = 0;
            while (!in_rsp_valid && t < 50) begin tick(); t++; end
            check("in_rsp_valid", in_rsp_valid, 1);
            // Zero-wait read: valid appears 2 edges per word after the accept
            // edge, i.e. in the 10th cycle counting the accept cycle as the 1st.
            if (req_stall == 0) check("rd_latency", cyc - c0, 2 * WORDS);
            for (int s = 0; s <= rsp_stall; s++) begin
                check("rsp_valid_hold", in_rsp_valid, 1);
                check("rsp_data", in_rsp_data, rd_line);
                check("rsp_tag", in_rsp_tag, tag);
                in_rsp_ready = (s == rsp_stall);
                if (s == rsp_stall) mon_probe = 1'b0;
                tick();
            end
            in_rsp_ready = 1'b0;
            check("rsp_done", in_rsp_valid, 0);
            check("rd_idle_ready", in_req_ready, 1);
            if (probe_busy) check("busy_no_ready", mon_busy, 0);
        end
        mon_probe = 1'b0;
        mon_write = 1'b0;
    endtask

    initial begin
        logic [LW-1:0]   rd;
        logic [BE_W-1:0] be;
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_outputs_zero", all_outputs(), '0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_ready", in_req_ready, 1);

        // Directed read, unaligned address, zero-wait bridge.
        rd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        run_line(1'b0, 16'hFFFF, 32'h0000_1004, rnd_line(), 1'b1, rd, 0, 0, 1'b0, -1);

        // Directed sparse write: only words 1 and 2 are enabled.
        run_line(1'b1, 16'h0F30, 32'h0000_2000, rnd_line(), 1'b0, '0, 0, 0, 1'b0, -1);

        // Write with no enabled bytes is swallowed.
        run_line(1'b1, 16'h0000, 32'h0000_3000, rnd_line(), 1'b1, '0, 0, 0, 1'b0, -1);

        // Backpressure on both the word request and the line response.
        run_line(1'b0, 16'h1234, 32'h0000_4010, rnd_line(), 1'b1, rnd_line(), 5, 3, 1'b0, -1);

        // Reset while waiting for word 1, then a clean read.
        run_line(1'b0, 16'hFFFF, 32'h0000_5000, rnd_line(), 1'b1, rnd_line(), 0, 0, 1'b0, 1);
        check("abort_gather_clear", in_rsp_data, '0);
        run_line(1'b0, 16'hFFFF, 32'h0000_5000, rnd_line(), 1'b0, rnd_line(), 0, 0, 1'b0, -1);

        // Second request held while busy, accepted right after the response.
        run_line(1'b0, 16'hFFFF, 32'h0000_6000, rnd_line(), 1'b1, rnd_line(), 0, 1, 1'b1, -1);
        run_line(1'b0, 16'hFFFF, 32'h0000_7020, rnd_line(), 1'b0, rnd_line(), 0, 0, 1'b0, -1);

        // Random lines.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: be = '0;
                1, 2: begin
                    be = '0;
                    be[$urandom_range(0, WORDS - 1)*4 +: 4] = 4'($urandom_range(1, 15));
                end
                default: be = BE_W'($urandom);
            endcase
            run_line(1'($urandom_range(0, 1)), be, $urandom, rnd_line(), TW'($urandom),
                     rnd_line(), -1, int'($urandom_range(0, 2)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/vx_mem_line_splitter.md
Name: vx_mem_line_splitter

Overview:
- Sits directly upstream of the 32-bit VX-to-OBI bridge, between the L2 shared cache memory-side port (line-wide VX mem req/rsp) and the bridge's 32-bit VX mem port.
- Splits each line write into per-word 32-bit writes and each line read into sequential 32-bit reads.
- Gathers read words back into one line-wide response that carries the original tag.
- Handles one line transaction at a time.

Parameters:
- LINE_WIDTH_BIT, 128, line width in bits; multiple of 32, at least 64. WORDS = LINE_WIDTH_BIT/32.
- TAG_WIDTH_BIT, 1, width of the line-side tag.
- WORD_TAG_WIDTH_BIT, max(1, clog2(WORDS)), width of the word-side tag, which carries the word index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_req_valid  in  1  line request valid.
- in_req_rw  in  1  1 = write, 0 = read.
- in_req_byteen  in  LINE_WIDTH_BIT/8  line byte enables; ignored for reads.
- in_req_addr  in  32  byte address; the low clog2(LINE_WIDTH_BIT/8) bits are treated as 0.
- in_req_data  in  LINE_WIDTH_BIT  write line.
- in_req_tag  in  TAG_WIDTH_BIT  line tag.
- in_req_ready  out  1  line request accepted.
- in_rsp_valid  out  1  read line response valid.
- in_rsp_data  out  LINE_WIDTH_BIT  read line; word i occupies bits [32i+31:32i].
- in_rsp_tag  out  TAG_WIDTH_BIT  tag of the captured request.
- in_rsp_ready  in  1  line response consumed.
- out_req_valid  out  1  word request valid (to bridge).
- out_req_rw  out  1  captured rw.
- out_req_byteen  out  4  byteen slice of the current word.
- out_req_addr  out  32  line base + 4*idx.
- out_req_data  out  32  data slice of the current word.
- out_req_tag  out  WORD_TAG_WIDTH_BIT  idx.
- out_req_ready  in  1  bridge accepted the word.
- out_rsp_valid  in  1  word read response valid.
- out_rsp_data  in  32  word read data.
- out_rsp_tag  in  WORD_TAG_WIDTH_BIT  returned word index.
- out_rsp_ready  out  1  word response consumed.

Behaviour:
- Clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset: FSM = IDLE; idx, all captured fields and the gather buffer = 0; every output = 0.
- Handshake: valid & ready on the same rising edge. Valid, once raised, never drops until the handshake completes. Every output is driven from registers or the FSM state only.
- States: IDLE, ISSUE, WAIT_RSP, SEND_RSP.
- IDLE:
  - in_req_ready = 1.
  - On in_req_valid, capture rw, byteen, addr (low bits cleared), data and tag; clear the gather buffer.
  - Read: idx = 0, go to ISSUE.
  - Write: idx = lowest word with a nonzero 4-bit byteen slice, go to ISSUE. If every slice is 0, stay in IDLE; no word is issued and the request is dropped silently.
- ISSUE:
  - out_req_valid = 1; fields are driven from the capture and idx.
  - On out_req_ready:
    - Read: go to WAIT_RSP.
    - Write: idx = next higher word with a nonzero slice, staying in ISSUE. If none remains, go to IDLE.
  - Writes never produce in_rsp.
- WAIT_RSP:
  - out_rsp_ready = 1.
  - On out_rsp_valid, write out_rsp_data into gather word idx (word index taken from idx; out_rsp_tag is not used for placement).
  - If idx == WORDS-1, go to SEND_RSP; else idx++ and go to ISSUE.
- SEND_RSP:
  - in_rsp_valid = 1; in_rsp_data = gather buffer; in_rsp_tag = captured tag.
  - On in_rsp_ready, go to IDLE.
- Latency:
  - Read with zero-wait bridge: 1 accept cycle + 2 cycles per word + 1 response cycle.
  - Write: 1 accept cycle + 1 cycle per enabled word.
- in_req_ready is 0 in every state except IDLE; back-to-back lines need at least one IDLE cycle between them.
- out_rsp_valid outside WAIT_RSP is not consumed (out_rsp_ready = 0).
- Reset asserted mid-transaction returns everything to reset values immediately; no word request is completed afterwards.
- idx is WORD_TAG_WIDTH_BIT wide and never wraps past WORDS-1.

Test Plan:
- Read, addr 0x0000_1004, tag 1, bridge returns 0xA0,0xA1,0xA2,0xA3 -> word reqs at 0x1000, 0x1004, 0x1008, 0x100C with tags 0..3, rw = 0; in_rsp_data = {0xA3,0xA2,0xA1,0xA0}, in_rsp_tag = 1; 10 cycles from accept to in_rsp_valid at zero wait.
- Write, addr 0x2000, byteen 0x0F30, data words W0..W3 -> exactly two reqs: 0x2004 with be 0x3 and data W1, then 0x2008 with be 0xF and data W2; no in_rsp; back in IDLE 1 cycle after the last accept.
- Write with byteen 0x0000 -> in_req_ready accepted, out_req_valid never asserted, FSM stays in IDLE.
- Backpressure: out_req_ready held low 5 cycles, then in_rsp_ready held low 3 cycles -> out_req fields stable throughout; in_rsp_valid and in_rsp_data stable until the handshake.
- rst_ni pulsed low while in WAIT_RSP after word 1 -> all outputs 0 asynchronously; a following read completes correctly with a gather buffer holding no stale data.
- Second line request presented while busy -> in_req_ready stays 0 until IDLE; request accepted the cycle after the prior in_rsp handshake.
